// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: one digit per clock, MSD first, via a
// x10 multiply-accumulate under a start/busy/done handshake; flags digits > 9.
module bcd2bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      binary_out,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FINISH
  } state_e;

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   sreg_q, sreg_d;
  logic [BIN_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_acc_q, err_acc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               err_q, err_d;

  logic [3:0]         digit;

  assign digit = sreg_q[BCD_W-1 -: 4];

  // NOTE: every signal driven here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_acc_d = err_acc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bin_d     = bin_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sreg_d    = bcd_in;
          acc_d     = '0;
          cnt_d     = '0;
          err_acc_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = CONV;
        end
      end

      CONV: begin
        // acc*10 + d, built from shifts; wraps only when a digit is invalid
        acc_d     = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);
        sreg_d    = sreg_q << 4;
        err_acc_d = err_acc_q | (digit > 4'd9);
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_DIGIT) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        bin_d   = err_acc_q ? '0 : acc_q;
        err_d   = err_acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_acc_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bin_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      sreg_q    <= sreg_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_acc_q <= err_acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bin_q     <= bin_d;
      err_q     <= err_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign binary_out = bin_q;
  assign err        = err_q;

endmodule
